// File: rtl/dpram_arb_pkg.sv
// rtl/dpram_arb_pkg.sv - shared types and round-robin pick helper for the DPRAM port arbiter
package dpram_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Upper bound on requesters the pick helper can scan; callers zero-extend into this width.
    localparam int unsigned MaxReq = 32;
    localparam int unsigned PickIdxW = 5;

    typedef struct packed {
        logic                valid;
        logic [PickIdxW-1:0] idx;
    } rr_pick_t;

    // First active request scanning prio, prio+1, ... wrapping at num (num need not be a power of 2).
    function automatic rr_pick_t rr_pick(
        input logic [MaxReq-1:0] req,
        input int unsigned       num,
        input int unsigned       prio
    );
        rr_pick_t    res;
        int unsigned k;
        res = '0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            if ((i < num) && !res.valid) begin
                k = prio + i;
                if (k >= num) begin
                    k = k - num;
                end
                if (req[k[PickIdxW-1:0]]) begin
                    res.valid = 1'b1;
                    res.idx   = k[PickIdxW-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_picker.sv
// rtl/dpram_port_arbiter_rr_picker.sv - combinational round-robin winner selection
module rr_picker
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   prio_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [MaxReq-1:0] w_req_ext;
    rr_pick_t          w_pick;

    // Widen the request vector to the helper's fixed width and run the scan.
    always_comb begin
        w_req_ext             = '0;
        w_req_ext[NumReq-1:0] = req_i;
        w_pick                = rr_pick(w_req_ext, NumReq, {{(32 - IdxW){1'b0}}, prio_i});
        valid_o               = w_pick.valid;
        idx_o                 = w_pick.idx[IdxW-1:0];
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - round-robin sharing of the DPRAM core port with hold-until-hit and watchdog
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned ByteLength    = 8,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                                         clk_i,
    input  logic                                         rstn_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]             req_addr_i,
    input  logic [NumReq-1:0]                            req_wren_i,
    input  logic [NumReq-1:0][DataWidth-1:0]             req_wdata_i,
    input  logic [NumReq-1:0][DataWidth/ByteLength-1:0]  req_wmask_i,
    input  logic [NumReq-1:0]                            req_rden_i,
    output logic [NumReq-1:0][DataWidth-1:0]             req_rdata_o,
    output logic [NumReq-1:0]                            req_hit_o,
    output logic [AddrWidth-1:0]                         m_addr_o,
    output logic                                         m_wren_o,
    output logic [DataWidth-1:0]                         m_wdata_o,
    output logic [DataWidth/ByteLength-1:0]              m_wmask_o,
    output logic                                         m_rden_o,
    input  logic [DataWidth-1:0]                         m_rdata_i,
    input  logic                                         m_hit_i,
    output logic [NumReq-1:0]                            grant_o,
    output logic                                         timeout_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned WdW  = $clog2(TimeoutCycles) + 1;

    arb_state_e       r_state;
    logic [IdxW-1:0]  r_prio;
    logic [IdxW-1:0]  r_grant;
    logic [WdW-1:0]   r_wdog;
    logic             r_timeout;

    logic [NumReq-1:0] w_req;
    logic [IdxW-1:0]   w_win;
    logic              w_win_valid;
    logic [IdxW-1:0]   w_sel_idx;
    logic              w_active;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] x);
        if (x == IdxW'(NumReq - 1)) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    assign w_req     = req_rden_i | req_wren_i;
    assign timeout_o = r_timeout;

    rr_picker #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_picker (
        .req_i   (w_req),
        .prio_i  (r_prio),
        .idx_o   (w_win),
        .valid_o (w_win_valid)
    );

    // Read data goes to everyone; each requester qualifies it with its own hit.
    for (genvar g = 0; g < NumReq; g++) begin : g_rdata
        assign req_rdata_o[g] = m_rdata_i;
    end

    // Owner selection: the locked grant while BUSY, the fresh winner while IDLE; held at zero during reset.
    always_comb begin
        w_sel_idx = (r_state == ARB_BUSY) ? r_grant : w_win;
        w_active  = rstn_i && ((r_state == ARB_BUSY) || w_win_valid);
        m_addr_o  = '0;
        m_wren_o  = 1'b0;
        m_wdata_o = '0;
        m_wmask_o = '0;
        m_rden_o  = 1'b0;
        req_hit_o = '0;
        grant_o   = '0;
        if (w_active) begin
            m_addr_o           = req_addr_i[w_sel_idx];
            m_wren_o           = req_wren_i[w_sel_idx];
            m_wdata_o          = req_wdata_i[w_sel_idx];
            m_wmask_o          = req_wmask_i[w_sel_idx];
            m_rden_o           = req_rden_i[w_sel_idx];
            grant_o[w_sel_idx] = 1'b1;
            req_hit_o[w_sel_idx] = m_hit_i && w_req[w_sel_idx];
        end
    end

    // Arbitration FSM with watchdog and sticky timeout flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= ARB_IDLE;
            r_prio    <= '0;
            r_grant   <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_win_valid) begin
                        if (m_hit_i) begin
                            r_prio <= next_idx(w_win);
                        end else begin
                            r_grant <= w_win;
                            r_wdog  <= WdW'(1);
                            r_state <= ARB_BUSY;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (w_req[r_grant] && m_hit_i) begin
                        r_prio  <= next_idx(r_grant);
                        r_state <= ARB_IDLE;
                    end else if (!w_req[r_grant]) begin
                        r_prio  <= next_idx(r_grant);
                        r_state <= ARB_IDLE;
                    end else if (r_wdog == WdW'(TimeoutCycles - 1)) begin
                        r_timeout <= 1'b1;
                        r_prio    <= next_idx(r_grant);
                        r_state   <= ARB_IDLE;
                    end else if (r_wdog != {WdW{1'b1}}) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
